// File: rtl/lepton_frame_sequencer_if.sv
// Stream bundle between the sequencer, the VoSPI SPI master (s_axis) and the frame buffer (m_axis).
// Modport master is the sequencer's view; modport slave is the surrounding system's view.
interface lepton_frame_sequencer_if;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/lepton_frame_sequencer.sv
// Lepton VoSPI frame sequencer: gates the SPI master, hunts packet 0 and re-emits a frame as AXI-Stream.
// Define LEPTON_FRAME_SEQ_STATS_EN to build the frame_count / error_count statistic counters.
module lepton_frame_sequencer #(
    parameter int PACKETS_PER_FRAME = 60,
    parameter int WORDS_PER_PACKET  = 41,
    parameter int RESYNC_CYCLES     = 18500000,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    output logic                            spi_en,
    input  logic                            spi_error,
    lepton_frame_sequencer_if.master        bus,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            sync_lost,
    output logic [15:0]                     frame_count,
    output logic [15:0]                     error_count
);
    // state     | meaning
    // S_IDLE    | link off, waiting for enable
    // S_RESYNC  | spi_en low for the CS idle period
    // S_HUNT    | link on, waiting for the header of packet 0
    // S_SKIP    | dropping the payload of a discard or unwanted packet
    // S_CAPTURE | emitting payload of in-sequence packets
    // S_DONE    | frame complete (one cycle)
    typedef enum logic [2:0] {
        S_IDLE, S_RESYNC, S_HUNT, S_SKIP, S_CAPTURE, S_DONE
    } state_e;

    localparam int WCW = $clog2(WORDS_PER_PACKET);
    localparam int RSW = $clog2(RESYNC_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_PACKET - 1);
    localparam logic [11:0]    PKT_END   = 12'(PACKETS_PER_FRAME);

    state_e         state_q, state_d;
    logic           ret_cap_q, ret_cap_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [11:0]    exp_q, exp_d;
    logic [RSW-1:0] rs_cnt_q, rs_cnt_d;
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic [31:0]    tdata_q, tdata_d;
    logic           tvalid_q, tvalid_d;
    logic           tlast_q, tlast_d;
    logic           tuser_q, tuser_d;
    logic           spi_en_q, busy_q, done_q, lost_q;
    logic           sync_err;

    logic           word_v, is_hdr, is_last, is_discard, active;
    logic [11:0]    hdr_num;

    assign word_v     = bus.s_axis_tvalid;
    assign is_hdr     = (wcnt_q == '0);
    assign is_last    = (wcnt_q == LAST_WORD);
    assign is_discard = (bus.s_axis_tdata[3:0] == 4'hF);
    assign hdr_num    = {bus.s_axis_tdata[3:0], bus.s_axis_tdata[15:8]};
    assign active     = (state_q == S_HUNT) || (state_q == S_SKIP) || (state_q == S_CAPTURE);

    always_comb begin
        state_d   = state_q;
        ret_cap_d = ret_cap_q;
        wcnt_d    = wcnt_q;
        exp_d     = exp_q;
        rs_cnt_d  = rs_cnt_q;
        to_cnt_d  = to_cnt_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tuser_d   = tuser_q;
        sync_err  = 1'b0;

        if (tvalid_q && bus.m_axis_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
        end

        // Words seen in DONE still advance the counter so packet alignment is never lost.
        if (word_v && (active || state_q == S_DONE)) begin
            wcnt_d = is_last ? '0 : wcnt_q + WCW'(1);
        end

        if (active) begin
            if (word_v) begin
                to_cnt_d = TOW'(TIMEOUT_CYCLES);
            end else if (to_cnt_q == '0) begin
                sync_err = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q - TOW'(1);
            end
            if (spi_error) begin
                sync_err = 1'b1;
            end
        end else begin
            to_cnt_d = TOW'(TIMEOUT_CYCLES);
        end

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_RESYNC;
            end
            S_RESYNC: begin
                if (rs_cnt_q == '0) state_d = S_HUNT;
                else                rs_cnt_d = rs_cnt_q - RSW'(1);
            end
            S_HUNT: begin
                if (word_v && is_hdr) begin
                    if (is_discard || hdr_num != 12'd0) begin
                        state_d   = S_SKIP;
                        ret_cap_d = 1'b0;
                    end else begin
                        state_d = S_CAPTURE;
                        exp_d   = 12'd1;
                    end
                end else if (!word_v && is_hdr && !enable) begin
                    state_d = S_IDLE;
                end
            end
            S_SKIP: begin
                if (word_v && is_last) state_d = ret_cap_q ? S_CAPTURE : S_HUNT;
            end
            S_CAPTURE: begin
                if (word_v && is_hdr) begin
                    if (is_discard) begin
                        state_d   = S_SKIP;
                        ret_cap_d = 1'b1;
                    end else if (hdr_num == exp_q) begin
                        exp_d = exp_q + 12'd1;
                    end else begin
                        sync_err = 1'b1;
                    end
                end else if (word_v) begin
                    if (tvalid_q && !bus.m_axis_tready) begin
                        sync_err = 1'b1;
                    end else begin
                        tvalid_d = 1'b1;
                        tdata_d  = bus.s_axis_tdata;
                        tlast_d  = is_last;
                        tuser_d  = (exp_q == 12'd1) && (wcnt_q == WCW'(1));
                        if (is_last && exp_q == PKT_END) state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = enable ? S_HUNT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (sync_err) begin
            state_d  = S_RESYNC;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
        end
        if (state_d == S_RESYNC && state_q != S_RESYNC) begin
            rs_cnt_d = RSW'(RESYNC_CYCLES);
            wcnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= S_IDLE;
            ret_cap_q <= 1'b0;
            wcnt_q    <= '0;
            exp_q     <= '0;
            rs_cnt_q  <= '0;
            to_cnt_q  <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            spi_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_cap_q <= ret_cap_d;
            wcnt_q    <= wcnt_d;
            exp_q     <= exp_d;
            rs_cnt_q  <= rs_cnt_d;
            to_cnt_q  <= to_cnt_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            spi_en_q  <= (state_d == S_HUNT) || (state_d == S_SKIP) ||
                         (state_d == S_CAPTURE) || (state_d == S_DONE);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            lost_q    <= sync_err;
        end
    end

`ifdef LEPTON_FRAME_SEQ_STATS_EN
    logic [15:0] frame_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (state_d == S_DONE) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (sync_err)          err_cnt_q   <= err_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
    assign error_count = err_cnt_q;
`else
    assign frame_count = '0;
    assign error_count = '0;
`endif

    assign spi_en            = spi_en_q;
    assign busy              = busy_q;
    assign frame_done        = done_q;
    assign sync_lost         = lost_q;
    assign bus.s_axis_tready = 1'b1;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.m_axis_tuser  = tuser_q;
endmodule

// File: tb/tb_lepton_frame_sequencer.sv
// Bench for lepton_frame_sequencer: random payloads checked against a packet-level model of the frame rules.
module tb_lepton_frame_sequencer;
    localparam int P  = 3;
    localparam int W  = 41;
    localparam int RC = 100;
    localparam int TO = 500;
`ifdef LEPTON_FRAME_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        spi_error = 1'b0;
    logic        spi_en, busy, frame_done, sync_lost;
    logic [15:0] frame_count, error_count;

    lepton_frame_sequencer_if bus_if ();

    lepton_frame_sequencer #(
        .PACKETS_PER_FRAME(P),
        .WORDS_PER_PACKET (W),
        .RESYNC_CYCLES    (RC),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .spi_en     (spi_en),
        .spi_error  (spi_error),
        .bus        (bus_if),
        .busy       (busy),
        .frame_done (frame_done),
        .sync_lost  (sync_lost),
        .frame_count(frame_count),
        .error_count(error_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [33:0] got[$];
    logic [33:0] expq[$];
    int          n_done = 0;
    int          n_lost = 0;
    int          exp_done = 0;
    int          exp_lost = 0;
    logic [15:0] exp_frames = '0;
    logic [15:0] exp_errors = '0;
    bit          m_hunting = 1'b1;
    int          m_next = 0;

    // Handshakes and pulses are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus_if.m_axis_tvalid === 1'b1 && bus_if.m_axis_tready === 1'b1)
            got.push_back({bus_if.m_axis_tuser, bus_if.m_axis_tlast, bus_if.m_axis_tdata});
        if (frame_done === 1'b1) n_done++;
        if (sync_lost === 1'b1) n_lost++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic note_error();
        exp_lost++;
        exp_errors++;
        m_hunting = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] data, input int gap);
        bus_if.s_axis_tdata  = data;
        bus_if.s_axis_tvalid = 1'b1;
        tick();
        bus_if.s_axis_tvalid = 1'b0;
        repeat (gap) tick();
    endtask

    function automatic logic [31:0] make_hdr(input int num, input bit discard);
        logic [31:0] h;
        h = $urandom;
        if (discard) begin
            h[3:0] = 4'hF;
        end else begin
            h[3:0]  = 4'(num >> 8);
            h[15:8] = 8'(num);
        end
        return h;
    endfunction

    // Model: a frame is packets 0..P-1 in order; discards vanish; an out-of-order number loses sync.
    task automatic send_packet(input int num, input bit discard, input int drop_en_at);
        bit          emit;
        bit          serr;
        logic [31:0] w;
        emit = 1'b0;
        serr = 1'b0;
        if (!discard) begin
            if (m_hunting) begin
                if (num == 0) begin
                    emit = 1'b1;
                    m_hunting = 1'b0;
                    m_next = 1;
                end
            end else if (num == m_next) begin
                emit = 1'b1;
                m_next++;
            end else begin
                serr = 1'b1;
                note_error();
            end
        end
        send_word(make_hdr(num, discard), serr ? 0 : int'($urandom_range(0, 2)));
        if (!serr) begin
            for (int i = 0; i < W - 1; i++) begin
                if (i == drop_en_at) enable = 1'b0;
                w = $urandom;
                if (emit) expq.push_back({(num == 0 && i == 0), (i == W - 2), w});
                send_word(w, (i == W - 2) ? 1 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 2)));
            end
            if (emit && m_next == P) begin
                m_hunting = 1'b1;
                exp_done++;
                exp_frames++;
            end
        end
    endtask

    task automatic wait_link(input string tag);
        int n;
        n = 0;
        while (spi_en !== 1'b1 && n < 4 * RC) begin
            tick();
            n++;
        end
        check({tag, "_link_up"}, 64'(spi_en), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic measure_resync(input string tag);
        int n;
        n = 0;
        while (spi_en === 1'b0 && n < 4 * RC) begin
            n++;
            tick();
        end
        check({tag, "_resync_len"}, 64'(n), 64'(RC + 1));
    endtask

    task automatic compare_output(input string tag);
        check({tag, "_word_count"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            check({tag, "_word"}, 64'(got[i]), 64'(expq[i]));
        got.delete();
        expq.delete();
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_frame_count"}, 64'(frame_count), STATS ? 64'(exp_frames) : 64'd0);
        check({tag, "_error_count"}, 64'(error_count), STATS ? 64'(exp_errors) : 64'd0);
        check({tag, "_done_pulses"}, 64'(n_done), 64'(exp_done));
        check({tag, "_lost_pulses"}, 64'(n_lost), 64'(exp_lost));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spi_en"},      64'(spi_en), 64'd0);
        check({tag, "_busy"},        64'(busy), 64'd0);
        check({tag, "_frame_done"},  64'(frame_done), 64'd0);
        check({tag, "_sync_lost"},   64'(sync_lost), 64'd0);
        check({tag, "_tvalid"},      64'(bus_if.m_axis_tvalid), 64'd0);
        check({tag, "_tlast"},       64'(bus_if.m_axis_tlast), 64'd0);
        check({tag, "_tuser"},       64'(bus_if.m_axis_tuser), 64'd0);
        check({tag, "_tdata"},       64'(bus_if.m_axis_tdata), 64'd0);
        check({tag, "_s_tready"},    64'(bus_if.s_axis_tready), 64'd1);
        check({tag, "_frame_count"}, 64'(frame_count), 64'd0);
        check({tag, "_error_count"}, 64'(error_count), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] w;
        int          k;

        bus_if.s_axis_tdata  = '0;
        bus_if.s_axis_tvalid = 1'b0;
        bus_if.m_axis_tready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b0;

        // Clean frame.
        enable = 1'b1;
        wait_link("clean");
        for (int p = 0; p < P; p++) send_packet(p, 1'b0, -1);
        repeat (5) tick();
        compare_output("clean");
        check_stats("clean");

        // Discard packets before packet 0 and between packets 1 and 2.
        send_packet(0, 1'b1, -1);
        send_packet(0, 1'b0, -1);
        send_packet(1, 1'b0, -1);
        send_packet(0, 1'b1, -1);
        send_packet(2, 1'b0, -1);
        repeat (5) tick();
        compare_output("discard");
        check_stats("discard");

        // Packet number mismatch: 0 then 2.
        send_packet(0, 1'b0, -1);
        send_packet(2, 1'b0, -1);
        check("mismatch_sync_lost", 64'(sync_lost), 64'd1);
        check("mismatch_spi_en", 64'(spi_en), 64'd0);
        measure_resync("mismatch");
        repeat (2) tick();
        compare_output("mismatch");
        check_stats("mismatch");

        // Backpressure: first payload word held, second one overflows.
        wait_link("bp");
        bus_if.m_axis_tready = 1'b0;
        send_word(make_hdr(0, 1'b0), 0);
        a = $urandom;
        send_word(a, 0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_tvalid", 64'(bus_if.m_axis_tvalid), 64'd1);
            check("bp_hold_tdata", 64'(bus_if.m_axis_tdata), 64'(a));
            check("bp_hold_tuser", 64'(bus_if.m_axis_tuser), 64'd1);
            tick();
        end
        b = $urandom;
        send_word(b, 0);
        note_error();
        check("bp_overflow_lost", 64'(sync_lost), 64'd1);
        check("bp_overflow_tvalid", 64'(bus_if.m_axis_tvalid), 64'd0);
        measure_resync("bp");
        bus_if.m_axis_tready = 1'b1;
        compare_output("bp");
        check_stats("bp");

        // Timeout: a 400-cycle stall is tolerated, a longer one loses sync after 501 idle cycles.
        wait_link("timeout");
        send_word(make_hdr(0, 1'b0), 0);
        for (int i = 0; i < 5; i++) begin
            w = $urandom;
            expq.push_back({(i == 0), 1'b0, w});
            send_word(w, int'($urandom_range(0, 2)));
        end
        repeat (400) tick();
        check("timeout_short_stall_link", 64'(spi_en), 64'd1);
        check("timeout_short_stall_lost", 64'(n_lost), 64'(exp_lost));
        for (int i = 5; i < 10; i++) begin
            w = $urandom;
            expq.push_back({1'b0, 1'b0, w});
            send_word(w, 0);
        end
        k = 0;
        while (sync_lost !== 1'b1 && k < 4 * TO) begin
            tick();
            k++;
        end
        note_error();
        check("timeout_idle_cycles", 64'(k), 64'(TO + 1));
        measure_resync("timeout");
        compare_output("timeout");
        check_stats("timeout");

        // spi_error while hunting.
        wait_link("spierr");
        spi_error = 1'b1;
        tick();
        spi_error = 1'b0;
        note_error();
        check("spierr_sync_lost", 64'(sync_lost), 64'd1);
        measure_resync("spierr");
        check_stats("spierr");

        // Reset in the middle of a capture.
        wait_link("midrst");
        bus_if.m_axis_tready = 1'b0;
        send_word(make_hdr(0, 1'b0), 0);
        a = $urandom | 32'd1;
        send_word(a, 0);
        check("midrst_pre_tvalid", 64'(bus_if.m_axis_tvalid), 64'd1);
        check("midrst_pre_tdata", 64'(bus_if.m_axis_tdata), 64'(a));
        rst_n = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst_n = 1'b0;
        bus_if.m_axis_tready = 1'b1;
        exp_frames = '0;
        exp_errors = '0;
        m_hunting = 1'b1;
        got.delete();
        expq.delete();

        // enable dropped during packet 1: frame still completes, then the link goes idle.
        wait_link("endrop");
        send_packet(0, 1'b0, -1);
        send_packet(1, 1'b0, 10);
        send_packet(2, 1'b0, -1);
        repeat (4) tick();
        compare_output("endrop");
        check("endrop_spi_en", 64'(spi_en), 64'd0);
        check("endrop_busy", 64'(busy), 64'd0);
        check_stats("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
